// File: rtl/tg_pkg.sv
// tg_pkg: shared definitions for the telegraph frame collector.
//   WORD_W_DEF / DEPTH_DEF : default word width and output FIFO depth
//   LEN_W_DEF              : width of a bit-length field (holds 0..WORD_W_DEF)
//   cap_state_t            : capture FSM state (IDLE = no bits held, COLLECT = 1..WORD_W-1 bits held)
//   tg_entry_t             : one output FIFO entry {data, len, partial}
package tg_pkg;

   localparam int WORD_W_DEF = 8;
   localparam int DEPTH_DEF  = 4;
   localparam int LEN_W_DEF  = $clog2(WORD_W_DEF) + 1;

   typedef enum logic {
      CAP_IDLE    = 1'b0,
      CAP_COLLECT = 1'b1
   } cap_state_t;

   // Entry layout is sized by the package defaults; a collector built with a
   // different WORD_W must change WORD_W_DEF together with it.
   typedef struct packed {
      logic [WORD_W_DEF-1:0] data;
      logic [LEN_W_DEF-1:0]  len;
      logic                  partial;
   } tg_entry_t;

endpackage

// File: rtl/tg_sync_fifo.sv
// tg_sync_fifo: single-clock FIFO with exact occupancy tracking.
//   clk, rst      : clock, asynchronous active-low reset
//   push/push_data: write request; accepted when not full, or when full and a pop
//                   happens on the same edge
//   pop           : read request; ignored while empty
//   pop_data      : head entry (meaningful only while empty=0)
//   full, empty   : occupancy == DEPTH / occupancy == 0
module tg_sync_fifo #(
   parameter int DATA_W = 13,
   parameter int DEPTH  = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              push,
   input  logic [DATA_W-1:0] push_data,
   input  logic              pop,
   output logic [DATA_W-1:0] pop_data,
   output logic              full,
   output logic              empty
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int OCC_W = $clog2(DEPTH) + 1;
   localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(DEPTH - 1);
   localparam logic [OCC_W-1:0] OCC_FULL = OCC_W'(DEPTH);

   logic [DATA_W-1:0] mem [DEPTH];
   logic [PTR_W-1:0]  wr_ptr;
   logic [PTR_W-1:0]  rd_ptr;
   logic [OCC_W-1:0]  occ;
   logic              do_push;
   logic              do_pop;

   assign full    = (occ == OCC_FULL);
   assign empty   = (occ == '0);
   assign do_pop  = pop & ~empty;
   // A same-edge pop frees the slot, so a push into a full FIFO still lands.
   assign do_push = push & (~full | do_pop);
   assign pop_data = mem[rd_ptr];

   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         occ    <= '0;
      end else begin
         if (do_push) wr_ptr <= (wr_ptr == PTR_LAST) ? '0 : wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= (rd_ptr == PTR_LAST) ? '0 : rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   occ <= occ + 1'b1;
            2'b01:   occ <= occ - 1'b1;
            default: occ <= occ;
         endcase
      end
   end

endmodule

// File: rtl/tg_frame_collector.sv
// tg_frame_collector: assembles the serial telegraph bit stream into words.
//   clk, rst    : clock, asynchronous active-low reset
//   ser_in      : serial bit, sampled MSB-first while ser_valid=1
//   ser_valid   : bit qualifier; a falling ser_valid closes a frame (burst)
//   clr_ovf     : synchronous clear of the sticky overflow flag
//   out_ready   : consumer ready
//   out_valid   : FIFO head holds a word
//   out_data    : head word, left-aligned, zero-padded when short
//   out_len     : real bits in out_data (1..WORD_W)
//   out_partial : head word was flushed before reaching WORD_W bits
//   ovf         : sticky, set when a push was dropped on a full FIFO
//   frame_cnt   : completed bursts, wraps at 256
//   dbg_state   : capture FSM state
//
// Output handshake: a word transfers on every rising edge where out_valid=1
// and out_ready=1; out_valid never depends on out_ready, and out_ready while
// out_valid=0 does nothing.
module tg_frame_collector
   import tg_pkg::*;
#(
   parameter int WORD_W = WORD_W_DEF,
   parameter int DEPTH  = DEPTH_DEF
) (
   input  logic                    clk,
   input  logic                    rst,
   input  logic                    ser_in,
   input  logic                    ser_valid,
   input  logic                    clr_ovf,
   input  logic                    out_ready,
   output logic                    out_valid,
   output logic [WORD_W-1:0]       out_data,
   output logic [$clog2(WORD_W):0] out_len,
   output logic                    out_partial,
   output logic                    ovf,
   output logic [7:0]              frame_cnt,
   output cap_state_t              dbg_state
);

   localparam int LEN_W = $clog2(WORD_W) + 1;
   localparam logic [LEN_W-1:0] CNT_LAST = LEN_W'(WORD_W - 1);
   localparam logic [LEN_W-1:0] LEN_FULL = LEN_W'(WORD_W);

   cap_state_t        state;
   cap_state_t        state_nxt;
   logic [LEN_W-1:0]  cnt;
   logic [WORD_W-1:0] sreg;
   logic              in_burst;
   logic              push;
   tg_entry_t         push_entry;
   tg_entry_t         head;
   logic              fifo_full;
   logic              fifo_empty;
   logic              pop;
   logic              drop;

   // ---------------- capture FSM: state register ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= CAP_IDLE;
      else      state <= state_nxt;
   end

   // ---------------- capture FSM: next state ----------------
   // COLLECT exactly while 1..WORD_W-1 bits are held; the WORD_W-th bit
   // empties the shift register, so the FSM drops back to IDLE with it.
   always_comb begin
      state_nxt = CAP_IDLE;
      if (ser_valid && (cnt != CNT_LAST)) state_nxt = CAP_COLLECT;
   end

   // ---------------- capture FSM: outputs (push request) ----------------
   always_comb begin
      push       = 1'b0;
      push_entry = '0;
      if (ser_valid && (cnt == CNT_LAST)) begin
         push               = 1'b1;
         push_entry.data    = {sreg[WORD_W-2:0], ser_in};
         push_entry.len     = LEN_FULL;
         push_entry.partial = 1'b0;
      end else if (!ser_valid && (state == CAP_COLLECT)) begin
         // sreg holds cnt bits right-aligned; shift them up to the MSBs.
         push               = 1'b1;
         push_entry.data    = sreg << (LEN_FULL - cnt);
         push_entry.len     = cnt;
         push_entry.partial = 1'b1;
      end
   end

   // ---------------- shift register, bit count, frame counter ----------------
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         cnt       <= '0;
         sreg      <= '0;
         in_burst  <= 1'b0;
         frame_cnt <= '0;
      end else if (ser_valid) begin
         in_burst <= 1'b1;
         if (cnt == CNT_LAST) begin
            cnt  <= '0;
            sreg <= '0;
         end else begin
            cnt  <= cnt + 1'b1;
            sreg <= {sreg[WORD_W-2:0], ser_in};
         end
      end else begin
         cnt  <= '0;
         sreg <= '0;
         // in_burst outlives cnt: a burst that ended on a word boundary
         // still has to be counted as a frame.
         if (in_burst) begin
            frame_cnt <= frame_cnt + 1'b1;
            in_burst  <= 1'b0;
         end
      end
   end

   // ---------------- overflow flag ----------------
   assign pop  = out_valid & out_ready;
   assign drop = push & fifo_full & ~pop;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)         ovf <= 1'b0;
      else if (drop)    ovf <= 1'b1;
      else if (clr_ovf) ovf <= 1'b0;
   end

   // ---------------- output FIFO ----------------
   tg_sync_fifo #(
      .DATA_W ($bits(tg_entry_t)),
      .DEPTH  (DEPTH)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (push),
      .push_data (push_entry),
      .pop       (out_ready),
      .pop_data  (head),
      .full      (fifo_full),
      .empty     (fifo_empty)
   );

   // Storage is not reset, so the head fields are forced to zero while empty.
   assign out_valid   = ~fifo_empty;
   assign out_data    = fifo_empty ? '0 : head.data;
   assign out_len     = fifo_empty ? '0 : head.len;
   assign out_partial = fifo_empty ? 1'b0 : head.partial;
   assign dbg_state   = state;

endmodule

// File: tb/tb_tg_frame_collector.sv
module tb_tg_frame_collector;
   import tg_pkg::*;

   localparam int W  = 8;
   localparam int D  = 4;
   localparam int LW = 4;

   typedef logic [W+LW:0] ent_t;   // {data, len, partial}

   typedef struct {
      bit         sv;
      bit         si;
      bit         rdy;
      bit         clr;
      bit         ev;
      logic [7:0] ed;
      logic [3:0] el;
      bit         ep;
      bit         eo;
      logic [7:0] ef;
   } vec_t;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   logic       ser_in = 1'b0;
   logic       ser_valid = 1'b0;
   logic       clr_ovf = 1'b0;
   logic       out_ready = 1'b0;
   logic       out_valid;
   logic [7:0] out_data;
   logic [3:0] out_len;
   logic       out_partial;
   logic       ovf;
   logic [7:0] frame_cnt;
   cap_state_t dbg_state;

   tg_frame_collector #(.WORD_W(W), .DEPTH(D)) dut (
      .clk         (clk),
      .rst         (rst),
      .ser_in      (ser_in),
      .ser_valid   (ser_valid),
      .clr_ovf     (clr_ovf),
      .out_ready   (out_ready),
      .out_valid   (out_valid),
      .out_data    (out_data),
      .out_len     (out_len),
      .out_partial (out_partial),
      .ovf         (ovf),
      .frame_cnt   (frame_cnt),
      .dbg_state   (dbg_state)
   );

   int total = 0;
   int bad   = 0;

   // ---------------- reference model ----------------
   ent_t       exp_q[$];
   bit         m_bits[$];
   bit         m_ovf;
   logic [7:0] m_frame;
   bit         m_burst;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      exp_q.delete();
      m_bits.delete();
      m_ovf   = 1'b0;
      m_frame = '0;
      m_burst = 1'b0;
   endtask

   function automatic ent_t bits_entry(bit partial);
      logic [W-1:0] w = '0;
      for (int i = 0; i < m_bits.size(); i++) w[W-1-i] = m_bits[i];
      return {w, LW'(m_bits.size()), partial};
   endfunction

   task automatic model_edge(input bit sv, input bit si, input bit rdy, input bit clr);
      int   pre  = exp_q.size();
      bit   pop  = (pre > 0) && rdy;
      bit   push = 1'b0;
      bit   drop = 1'b0;
      ent_t e    = '0;
      if (sv) begin
         m_burst = 1'b1;
         m_bits.push_back(si);
         if (m_bits.size() == W) begin
            e = bits_entry(1'b0);
            push = 1'b1;
            m_bits.delete();
         end
      end else if (m_burst) begin
         m_frame++;
         m_burst = 1'b0;
         if (m_bits.size() > 0) begin
            e = bits_entry(1'b1);
            push = 1'b1;
            m_bits.delete();
         end
      end
      if (pop) void'(exp_q.pop_front());
      if (push) begin
         if (pre == D && !pop) drop = 1'b1;
         else exp_q.push_back(e);
      end
      if (drop)     m_ovf = 1'b1;
      else if (clr) m_ovf = 1'b0;
   endtask

   function automatic logic [23:0] act_vec();
      return {out_valid, out_data, out_len, out_partial, ovf, frame_cnt, dbg_state == CAP_COLLECT};
   endfunction

   task automatic model_check(input string tag);
      ent_t head = (exp_q.size() > 0) ? exp_q[0] : '0;
      bit   st   = (m_bits.size() > 0);
      chk(tag, act_vec(), {exp_q.size() > 0, head, m_ovf, m_frame, st});
   endtask

   // ---------------- driver ----------------
   task automatic step(input bit sv, input bit si, input bit rdy, input bit clr);
      ser_valid = sv;
      ser_in    = si;
      out_ready = rdy;
      clr_ovf   = clr;
      @(posedge clk);
      model_edge(sv, si, rdy, clr);
      @(negedge clk);
      model_check("model");
   endtask

   task automatic do_reset();
      ser_valid = 1'b0;
      ser_in    = 1'b0;
      out_ready = 1'b0;
      clr_ovf   = 1'b0;
      rst = 1'b0;
      @(negedge clk);
      @(negedge clk);
      model_reset();
      chk("reset_state", act_vec(), '0);
      rst = 1'b1;
   endtask

   function automatic vec_t v(bit sv, bit si, bit rdy, bit ev, logic [7:0] ed,
                              logic [3:0] el, bit ep, logic [7:0] ef);
      vec_t r;
      r.sv = sv; r.si = si; r.rdy = rdy; r.clr = 1'b0;
      r.ev = ev; r.ed = ed; r.el = el; r.ep = ep; r.eo = 1'b0; r.ef = ef;
      return r;
   endfunction

   vec_t       tbl[15];
   logic [7:0] words[5];

   initial begin
      // ---- table: 0xB2 full word, then 3-bit burst 1,1,0 ----
      tbl[0]  = v(1, 1, 0, 0, 8'h00, 4'd0, 0, 8'd0);
      tbl[1]  = v(1, 0, 0, 0, 8'h00, 4'd0, 0, 8'd0);
      tbl[2]  = v(1, 1, 0, 0, 8'h00, 4'd0, 0, 8'd0);
      tbl[3]  = v(1, 1, 0, 0, 8'h00, 4'd0, 0, 8'd0);
      tbl[4]  = v(1, 0, 0, 0, 8'h00, 4'd0, 0, 8'd0);
      tbl[5]  = v(1, 0, 0, 0, 8'h00, 4'd0, 0, 8'd0);
      tbl[6]  = v(1, 1, 0, 0, 8'h00, 4'd0, 0, 8'd0);
      tbl[7]  = v(1, 0, 0, 1, 8'hB2, 4'd8, 0, 8'd0);
      tbl[8]  = v(0, 0, 0, 1, 8'hB2, 4'd8, 0, 8'd1);
      tbl[9]  = v(0, 0, 1, 0, 8'h00, 4'd0, 0, 8'd1);
      tbl[10] = v(1, 1, 0, 0, 8'h00, 4'd0, 0, 8'd1);
      tbl[11] = v(1, 1, 0, 0, 8'h00, 4'd0, 0, 8'd1);
      tbl[12] = v(1, 0, 0, 0, 8'h00, 4'd0, 0, 8'd1);
      tbl[13] = v(0, 0, 0, 1, 8'hC0, 4'd3, 1, 8'd2);
      tbl[14] = v(0, 0, 1, 0, 8'h00, 4'd0, 0, 8'd2);

      do_reset();
      for (int i = 0; i < 15; i++) begin
         step(tbl[i].sv, tbl[i].si, tbl[i].rdy, tbl[i].clr);
         chk($sformatf("tbl[%0d]", i),
             {out_valid, out_data, out_len, out_partial, ovf, frame_cnt},
             {tbl[i].ev, tbl[i].ed, tbl[i].el, tbl[i].ep, tbl[i].eo, tbl[i].ef});
      end

      // ---- overflow: 5 words with out_ready=0, clear, drain in order ----
      for (int k = 0; k < 5; k++) words[k] = 8'($urandom_range(0, 255));
      for (int k = 0; k < 5; k++)
         for (int b = 0; b < W; b++) step(1'b1, words[k][W-1-b], 1'b0, 1'b0);
      chk("ovf_set", ovf, 1);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b1);
      chk("ovf_clr", ovf, 0);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("drain%0d", k), {out_valid, out_data}, {1'b1, words[k]});
         step(1'b0, 1'b0, 1'b1, 1'b0);
      end
      chk("drained_empty", out_valid, 0);

      // ---- full FIFO with a same-edge pop on the 5th push ----
      for (int k = 0; k < 5; k++) words[k] = 8'($urandom_range(0, 255));
      for (int k = 0; k < 5; k++)
         for (int b = 0; b < W; b++)
            step(1'b1, words[k][W-1-b], (k == 4) && (b == W - 1), 1'b0);
      chk("no_drop_ovf", ovf, 0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      for (int k = 0; k < 4; k++) begin
         chk($sformatf("keep%0d", k), {out_valid, out_data}, {1'b1, words[k+1]});
         step(1'b0, 1'b0, 1'b1, 1'b0);
      end
      chk("occ4_empty", out_valid, 0);

      // ---- reset in the middle of a burst ----
      for (int b = 0; b < 5; b++) step(1'b1, 1'b1, 1'b0, 1'b0);
      chk("mid_state", dbg_state, CAP_COLLECT);
      #2 rst = 1'b0;
      ser_valid = 1'b0;
      #1 chk("async_rst", act_vec(), '0);
      model_reset();
      @(negedge clk);
      chk("rst_hold", act_vec(), '0);
      rst = 1'b1;
      for (int b = 0; b < W; b++) step(1'b1, b[0], 1'b0, 1'b0);
      step(1'b0, 1'b0, 1'b0, 1'b0);
      chk("post_rst_entry", {out_valid, out_data, out_len, out_partial, frame_cnt},
          {1'b1, 8'h55, 4'd8, 1'b0, 8'd1});
      step(1'b0, 1'b0, 1'b1, 1'b0);
      chk("post_rst_one", out_valid, 0);

      // ---- 256 single-bit bursts: frame_cnt wraps ----
      do_reset();
      for (int i = 0; i < 256; i++) begin
         step(1'b1, i[0], 1'b0, 1'b0);
         step(1'b0, 1'b0, 1'b0, 1'b0);
         chk("single_bit", {out_valid, out_data, out_len, out_partial},
             {1'b1, i[0], 7'd0, 4'd1, 1'b1});
         step(1'b0, 1'b0, 1'b1, 1'b0);
      end
      chk("frame_wrap", frame_cnt, 0);

      // ---- randomized traffic against the model ----
      for (int ph = 0; ph < 3; ph++) begin
         for (int n = 0; n < 1000; n++) begin
            step($urandom_range(0, 9) < 7,
                 1'($urandom_range(0, 1)),
                 $urandom_range(0, 3) < ph + 1,
                 $urandom_range(0, 31) == 0);
         end
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/tg_frame_collector.md
TG_FRAME_COLLECTOR -- requirements
Module: tg_frame_collector

Interface
REQ-001 The block SHALL have parameter WORD_W, default 8, giving data bits per assembled word.
REQ-002 The block SHALL have parameter DEPTH, default 4, giving output FIFO entries (power of two).
REQ-003 Port clk, input, 1, the single system clock; all state SHALL change on its rising edge only.
REQ-004 Port rst, input, 1, reset; it SHALL be asynchronous and active-low.
REQ-005 Port ser_in, input, 1, serial data bit from the upstream telegraph FSM's SerOut.
REQ-006 Port ser_valid, input, 1, qualifier from the upstream SerOutValid; ser_in SHALL be sampled only while it is 1.
REQ-007 Port clr_ovf, input, 1, synchronous clear of the overflow flag.
REQ-008 Port out_ready, input, 1, consumer ready.
REQ-009 Port out_valid, output, 1, FIFO head holds a word.
REQ-010 Port out_data, output, WORD_W, FIFO head word.
REQ-011 Port out_len, output, $clog2(WORD_W)+1, number of real bits in out_data (1..WORD_W).
REQ-012 Port out_partial, output, 1, head word was flushed short (out_len < WORD_W).
REQ-013 Port ovf, output, 1, sticky flag: a push was dropped.
REQ-014 Port frame_cnt, output, 8, count of completed ser_valid bursts.

Function
REQ-015 The capture FSM SHALL have states IDLE (bit count 0) and COLLECT (bit count 1..WORD_W-1).
REQ-016 On a clk edge with ser_valid=1, ser_in SHALL be shifted in MSB-first and the bit count incremented; IDLE->COLLECT on the first bit.
REQ-017 When the sampled bit is the WORD_W-th, the full word SHALL be pushed with out_len=WORD_W, out_partial=0, and the count SHALL return to 0, staying in or re-entering COLLECT per REQ-016 on the next bit.
REQ-018 On the first edge with ser_valid=0 after one or more ones, frame_cnt SHALL increment, wrapping 255->0.
REQ-019 If the count is nonzero at that edge, the partial word SHALL be pushed left-aligned with zero-padded LSBs, out_len=count, out_partial=1, and the FSM SHALL return to IDLE.
REQ-020 A pushed word SHALL be visible at the FIFO head (out_valid=1 if the FIFO was empty) in the cycle after the pushing edge.
REQ-021 A pop SHALL occur on an edge where out_valid=1 and out_ready=1; out_ready while empty SHALL have no effect.
REQ-022 Push when full without a same-edge pop SHALL be dropped and SHALL set ovf; push and pop on the same edge when full SHALL both succeed.
REQ-023 ovf SHALL stay set until clr_ovf=1 or reset; if clr_ovf and a dropping push coincide, ovf SHALL remain 1.
REQ-024 FIFO pointers SHALL wrap modulo DEPTH, with occupancy 0..DEPTH tracked exactly.

Reset
REQ-025 While rst=0: FSM=IDLE, shift register and bit count = 0, FIFO empty, out_valid=0, out_data=0, out_len=0, out_partial=0, ovf=0, frame_cnt=0.
REQ-026 Reset mid-word SHALL discard the partial word without pushing it or counting a frame.

Structure
REQ-027 Package tg_pkg SHALL hold WORD_W/DEPTH defaults, the capture state enum, and the FIFO entry struct {data, len, partial}.
REQ-028 The FIFO SHALL be a sub-module tg_sync_fifo (push/pop/full/empty, same clk/rst); capture, flush and counters SHALL stay in tg_frame_collector.

Verification
REQ-029 Hold ser_valid=1 for 8 cycles with bits 1,0,1,1,0,0,1,0 -> one entry out_data=8'hB2, out_len=8, out_partial=0; frame_cnt=1 after ser_valid falls.
REQ-030 Burst of 3 bits 1,1,0 then ser_valid=0 -> out_data=8'hC0, out_len=3, out_partial=1, frame_cnt=1.
REQ-031 With out_ready=0, push 5 full words -> 4 entries kept, ovf=1; pulse clr_ovf -> ovf=0; drain order matches push order.
REQ-032 FIFO full with out_ready=1 on the same edge as the 5th push -> no drop, ovf=0, occupancy stays 4.
REQ-033 Assert rst=0 after 5 bits of a burst -> all outputs 0 and no entry; after release, an 8-bit burst yields exactly one entry.
REQ-034 Run 256 single-bit bursts -> frame_cnt wraps to 0 and each burst yields out_len=1, out_partial=1.
